reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of each register and of the bus.
REQ-002 Parameter NREGS, default 4, number of registers; legal range 2..16.
REQ-003 Parameter SETTLE, default 2, relay settle time in cycles for load and select; legal range 1..15.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 ld_en  in  NREGS  per-register load request, level, expected one-hot.
REQ-007 sel_en  in  NREGS  per-register bus-drive request, level, expected one-hot.
REQ-008 data_in  in  WIDTH  data bus value to load.
REQ-009 data_out  out  WIDTH  bus drive from the selected register; 0 when not driving.
REQ-010 data_out_vld  out  1  high while data_out carries register content.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 err  out  1  one-cycle pulse on an illegal or aborted request.
REQ-013 reg_q  out  NREGS*WIDTH  continuous content of all registers; register i at bits [i*WIDTH +: WIDTH].
REQ-014 led_ld, led_sel  out  NREGS each  indicator copies of the accepted request.

Function
REQ-015 The FSM SHALL have states IDLE, LD_SETTLE, SEL_SETTLE and SEL_DRIVE.
REQ-016 IDLE, ld_en one-hot: latch data_in and the index into staging, load cnt with SETTLE-1, go to LD_SETTLE.
REQ-017 IDLE, ld_en zero, sel_en one-hot: latch the index, load cnt with SETTLE-1, go to SEL_SETTLE.
REQ-018 ld_en non-zero SHALL take priority over sel_en in IDLE; sel_en is ignored that cycle without err.
REQ-019 IDLE, ld_en or sel_en with more than one bit set: pulse err, stay IDLE, change nothing.
REQ-020 LD_SETTLE: decrement cnt each cycle; at cnt==0 with the latched ld_en bit still high, write staging to the register and return to IDLE; the new value SHALL appear on reg_q in the following cycle, giving SETTLE+1 cycles from request to reg_q.
REQ-021 LD_SETTLE, latched ld_en bit dropped before cnt==0: abort with no write, pulse err, return to IDLE.
REQ-022 SEL_SETTLE: at cnt==0 go to SEL_DRIVE; on a dropped sel bit, abort to IDLE with an err pulse.
REQ-023 SEL_DRIVE: data_out equals the current register content and data_out_vld is 1 while the latched sel bit stays high; when it drops, go to IDLE and set data_out to 0.
REQ-024 New requests outside IDLE SHALL be ignored, without err.
REQ-025 Staging data_in SHALL be sampled only at acceptance; later changes to data_in SHALL have no effect.
REQ-026 Registers not addressed SHALL hold their value.
REQ-027 The counter SHALL be $clog2(SETTLE+1) bits wide, with no wrap below 0.

Reset
REQ-028 rst_n low at a clock edge SHALL set the FSM to IDLE and clear all registers, staging, cnt, data_out, data_out_vld, busy, err, led_ld and led_sel to 0, including mid-operation, with no pending write committed.

Configuration
REQ-029 Macro REG_BANK_LED_EN defined: led_ld and led_sel SHALL equal the latched one-hot index while in LD_SETTLE and in SEL_SETTLE/SEL_DRIVE respectively, and 0 otherwise.
REQ-030 Macro REG_BANK_LED_EN undefined: the led_ld and led_sel ports SHALL remain present and tied to 0; no other behaviour changes.

Structure
REQ-031 Package relay_pkg SHALL hold the FSM state enum and default WIDTH/NREGS/SETTLE constants.
REQ-032 Sub-module reg_cell (one WIDTH-bit register, sync reset, load enable) SHALL be instantiated NREGS times through generate.

Verification
REQ-033 Reset, then ld_en=4'b0100 with data_in=8'hA5 held for 3 cycles (SETTLE=2) -> reg_q[23:16]=8'hA5 on cycle 3, other registers 0, busy high for 2 cycles.
REQ-034 After REQ-033, sel_en=4'b0100 held for 6 cycles -> data_out=8'hA5 and data_out_vld=1 from cycle 3 through cycle 6; data_out=0 the cycle after sel drops.
REQ-035 ld_en=4'b0011 -> err pulses for 1 cycle, busy stays 0, reg_q unchanged.
REQ-036 ld_en=4'b0001 and sel_en=4'b0010 together -> load of register 0 proceeds, no select, no err.
REQ-037 ld_en=4'b1000 dropped after 1 cycle -> err pulses, register 3 unchanged.
REQ-038 rst_n low during LD_SETTLE -> IDLE, all reg_q 0, no write after reset release.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and defaults for the relay-style register bank.
// FSM state encoding, default geometry, and a one-hot helper.
package relay_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LD_SETTLE  = 2'd1,
        SEL_SETTLE = 2'd2,
        SEL_DRIVE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NREGS  = 4;
    localparam int DEF_SETTLE = 2;

    // Request vectors are zero-extended to 16 bits (NREGS never exceeds 16).
    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Request/bus bundle between a sequencer (master) and reg_bank (slave).
interface reg_bank_if
    import relay_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS
);
    logic [NREGS-1:0] ld_en;
    logic [NREGS-1:0] sel_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             data_out_vld;
    logic             busy;
    logic             err;

    modport master (
        output ld_en, sel_en, data_in,
        input  data_out, data_out_vld, busy, err
    );

    modport slave (
        input  ld_en, sel_en, data_in,
        output data_out, data_out_vld, busy, err
    );
endinterface

// File: rtl/reg_cell.sv
// One WIDTH-bit storage register with synchronous active-low reset and load enable.
module reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = ld ? d : val_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) val_q <= '0;
        else        val_q <= val_d;
    end

    assign q = val_q;
endmodule

// File: rtl/reg_bank.sv
// Relay-style register bank: settled loads and settled bus selects on a bank of reg_cells.
// Optional macro REG_BANK_LED_EN drives led_ld/led_sel from the accepted request; otherwise they read 0.
//
// state      | meaning
// IDLE       | waiting for a one-hot ld_en or sel_en request
// LD_SETTLE  | load relay settling; write staging to the register when cnt reaches 0
// SEL_SETTLE | select relay settling; begin driving the bus when cnt reaches 0
// SEL_DRIVE  | driving the selected register onto data_out while sel stays high
module reg_bank
    import relay_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_bank_if.slave              bus,
    output logic [NREGS*WIDTH-1:0] reg_q,
    output logic [NREGS-1:0]       led_ld,
    output logic [NREGS-1:0]       led_sel
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREGS-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] stg_q, stg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [NREGS-1:0] wr_en;
    logic [WIDTH-1:0] cell_q [NREGS];
    logic [WIDTH-1:0] sel_val;
    logic             ld_held, sel_held;

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_cell
            reg_cell #(.WIDTH(WIDTH)) u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .ld    (wr_en[g]),
                .d     (stg_q),
                .q     (cell_q[g])
            );
            assign reg_q[g*WIDTH +: WIDTH] = cell_q[g];
        end
    endgenerate

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx_q[i]) sel_val = cell_q[i];
        end
    end

    // The request that was accepted must stay asserted for the whole settle window.
    assign ld_held  = |(bus.ld_en  & idx_q);
    assign sel_held = |(bus.sel_en & idx_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        wr_en   = '0;
        case (state_q)
            IDLE: begin
                dout_d = '0;
                vld_d  = 1'b0;
                if (|bus.ld_en) begin
                    if (is_onehot(16'(bus.ld_en))) begin
                        state_d = LD_SETTLE;
                        cnt_d   = CNT_INIT;
                        idx_d   = bus.ld_en;
                        stg_d   = bus.data_in;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (|bus.sel_en) begin
                    if (is_onehot(16'(bus.sel_en))) begin
                        state_d = SEL_SETTLE;
                        cnt_d   = CNT_INIT;
                        idx_d   = bus.sel_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LD_SETTLE: begin
                if (!ld_held) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    wr_en   = idx_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SEL_SETTLE: begin
                if (!sel_held) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = SEL_DRIVE;
                    dout_d  = sel_val;
                    vld_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SEL_DRIVE: begin
                if (sel_held) begin
                    dout_d = sel_val;
                    vld_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    dout_d  = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stg_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.data_out_vld = vld_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;

`ifdef REG_BANK_LED_EN
    logic [NREGS-1:0] led_ld_q, led_ld_d;
    logic [NREGS-1:0] led_sel_q, led_sel_d;

    always_comb begin
        led_ld_d  = (state_d == LD_SETTLE) ? idx_d : '0;
        led_sel_d = (state_d == SEL_SETTLE || state_d == SEL_DRIVE) ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_ld_q  <= '0;
            led_sel_q <= '0;
        end else begin
            led_ld_q  <= led_ld_d;
            led_sel_q <= led_sel_d;
        end
    end

    assign led_ld  = led_ld_q;
    assign led_sel = led_sel_q;
`else
    assign led_ld  = '0;
    assign led_sel = '0;
`endif
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios with literal expectations,
// then randomized request bursts checked every cycle against a cycle-count model.
module tb_reg_bank;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int ST = 2;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_SSET  = 2;
    localparam int P_DRIVE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*W-1:0] reg_q;
    logic [N-1:0] led_ld, led_sel;

    reg_bank_if #(.WIDTH(W), .NREGS(N)) bus ();

    reg_bank #(.WIDTH(W), .NREGS(N), .SETTLE(ST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .reg_q   (reg_q),
        .led_ld  (led_ld),
        .led_sel (led_sel)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the accepted request by integer index and an up-count
    // of cycles since acceptance, compared against the settle time.
    int         phase = P_IDLE;
    int         tgt = 0;
    int         age = 0;
    logic [W-1:0] m_reg [N];
    logic [W-1:0] m_stg = '0;
    logic [W-1:0] e_dout = '0;
    logic       e_vld = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [N-1:0] e_led_ld = '0, e_led_sel = '0;
    logic [N*W-1:0] e_regq;

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin : model
        logic [N-1:0] l, s;
        logic [W-1:0] d;
        logic         r;
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        forever begin
            @(posedge clk);
            l = bus.ld_en; s = bus.sel_en; d = bus.data_in; r = rst_n;
            e_err = 1'b0;
            if (!r) begin
                for (int i = 0; i < N; i++) m_reg[i] = '0;
                phase = P_IDLE; age = 0; m_stg = '0; e_dout = '0; e_vld = 1'b0;
            end else begin
                case (phase)
                    P_IDLE: begin
                        e_dout = '0; e_vld = 1'b0;
                        if (l != 0) begin
                            if ($countones(l) == 1) begin
                                phase = P_LOAD; tgt = idx_of(l); age = 0; m_stg = d;
                            end else e_err = 1'b1;
                        end else if (s != 0) begin
                            if ($countones(s) == 1) begin
                                phase = P_SSET; tgt = idx_of(s); age = 0;
                            end else e_err = 1'b1;
                        end
                    end
                    P_LOAD: begin
                        age++;
                        if (!l[tgt]) begin phase = P_IDLE; e_err = 1'b1; end
                        else if (age == ST) begin m_reg[tgt] = m_stg; phase = P_IDLE; end
                    end
                    P_SSET: begin
                        age++;
                        if (!s[tgt]) begin phase = P_IDLE; e_err = 1'b1; end
                        else if (age == ST) begin
                            phase = P_DRIVE; e_dout = m_reg[tgt]; e_vld = 1'b1;
                        end
                    end
                    default: begin
                        if (s[tgt]) begin e_dout = m_reg[tgt]; e_vld = 1'b1; end
                        else begin phase = P_IDLE; e_dout = '0; e_vld = 1'b0; end
                    end
                endcase
            end
            e_busy = (phase != P_IDLE);
`ifdef REG_BANK_LED_EN
            e_led_ld  = (phase == P_LOAD) ? N'(1 << tgt) : '0;
            e_led_sel = (phase == P_SSET || phase == P_DRIVE) ? N'(1 << tgt) : '0;
`else
            e_led_ld  = '0;
            e_led_sel = '0;
`endif
            for (int i = 0; i < N; i++) e_regq[i*W +: W] = m_reg[i];
            @(negedge clk);
            chk("mdl_reg_q",   64'(reg_q),            64'(e_regq));
            chk("mdl_dout",    64'(bus.data_out),     64'(e_dout));
            chk("mdl_vld",     64'(bus.data_out_vld), 64'(e_vld));
            chk("mdl_busy",    64'(bus.busy),         64'(e_busy));
            chk("mdl_err",     64'(bus.err),          64'(e_err));
            chk("mdl_led_ld",  64'(led_ld),           64'(e_led_ld));
            chk("mdl_led_sel", 64'(led_sel),          64'(e_led_sel));
        end
    end

    // Apply inputs for one cycle; returns at the next negedge with the resulting outputs.
    task automatic step(input logic [N-1:0] l, input logic [N-1:0] s, input logic [W-1:0] d);
        bus.ld_en = l; bus.sel_en = s; bus.data_in = d;
        @(negedge clk);
    endtask

    initial begin : stim
        logic [N-1:0] l, s;
        int kind, hold, gap;
        bus.ld_en = '0; bus.sel_en = '0; bus.data_in = '0;
        rst_n = 1'b0;
        step('0, '0, '0);
        step('0, '0, '0);
        chk("reset_reg_q", 64'(reg_q), 64'h0);
        chk("reset_busy",  64'(bus.busy), 64'h0);
        rst_n = 1'b1;

        // Load 0xA5 into register 2.
        step(4'b0100, '0, 8'hA5);
        chk("ld_c1_busy",  64'(bus.busy), 64'h1);
        chk("ld_c1_reg_q", 64'(reg_q), 64'h0);
        step(4'b0100, '0, 8'h11);
        chk("ld_c2_busy",  64'(bus.busy), 64'h1);
        step(4'b0100, '0, 8'h22);
        chk("ld_c3_reg_q", 64'(reg_q), 64'h00A50000);
        chk("ld_c3_busy",  64'(bus.busy), 64'h0);

        // Select register 2 for six cycles.
        for (int k = 1; k <= 6; k++) begin
            step('0, 4'b0100, 8'h5A);
            if (k < 3) chk("sel_early_vld", 64'(bus.data_out_vld), 64'h0);
            else begin
                chk("sel_dout", 64'(bus.data_out), 64'hA5);
                chk("sel_vld",  64'(bus.data_out_vld), 64'h1);
            end
        end
        step('0, '0, '0);
        chk("sel_drop_dout", 64'(bus.data_out), 64'h0);
        chk("sel_drop_vld",  64'(bus.data_out_vld), 64'h0);

        // Multi-bit load request.
        step(4'b0011, '0, 8'hFF);
        chk("multi_err",   64'(bus.err), 64'h1);
        chk("multi_busy",  64'(bus.busy), 64'h0);
        chk("multi_reg_q", 64'(reg_q), 64'h00A50000);
        step('0, '0, '0);
        chk("multi_err_end", 64'(bus.err), 64'h0);

        // Load and select together: load wins silently.
        step(4'b0001, 4'b0010, 8'h3C);
        chk("prio_err",  64'(bus.err), 64'h0);
        chk("prio_busy", 64'(bus.busy), 64'h1);
        step(4'b0001, 4'b0010, 8'hC3);
        step(4'b0001, 4'b0010, 8'hC3);
        chk("prio_reg_q", 64'(reg_q), 64'h00A5003C);
        chk("prio_vld",   64'(bus.data_out_vld), 64'h0);
        step('0, '0, '0);

        // Aborted load.
        step(4'b1000, '0, 8'h77);
        chk("abort_busy", 64'(bus.busy), 64'h1);
        step('0, '0, 8'h77);
        chk("abort_err",  64'(bus.err), 64'h1);
        chk("abort_idle", 64'(bus.busy), 64'h0);
        step('0, '0, '0);
        chk("abort_reg_q", 64'(reg_q), 64'h00A5003C);

        // Reset in the middle of a load.
        step(4'b0010, '0, 8'h99);
        rst_n = 1'b0;
        step(4'b0010, '0, 8'h99);
        chk("rst_mid_reg_q", 64'(reg_q), 64'h0);
        chk("rst_mid_busy",  64'(bus.busy), 64'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step('0, '0, 8'h99);
        chk("rst_after_reg_q", 64'(reg_q), 64'h0);

        // Randomized bursts; data_in changes every cycle.
        for (int b = 0; b < 250; b++) begin
            kind = $urandom_range(0, 9);
            l = '0; s = '0;
            case (kind)
                0, 1, 2, 3: l = N'(1 << $urandom_range(0, N-1));
                4, 5, 6:    s = N'(1 << $urandom_range(0, N-1));
                7: begin l = N'($urandom_range(3, 15)); if ($countones(l) < 2) l = 4'b1111; end
                8: begin l = N'(1 << $urandom_range(0, N-1)); s = N'($urandom_range(0, 15)); end
                default: begin s = N'($urandom_range(3, 15)); if ($countones(s) < 2) s = 4'b0101; end
            endcase
            hold = $urandom_range(1, ST + 4);
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
                step(l, s, W'($urandom));
                rst_n = 1'b1;
            end
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) step('0, '0, W'($urandom));
        end
        step('0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
